// File: rtl/shift_pkg.sv
// Shared types and constants for the shift command path: operand/amount widths,
// direction encoding and the buffered command record.
package shift_pkg;

   localparam int DATA_W = 32;
   localparam int AMT_W  = 5;

   localparam logic DIR_LEFT  = 1'b0;
   localparam logic DIR_RIGHT = 1'b1;

   typedef struct packed {
      logic [DATA_W-1:0] data;
      logic [AMT_W-1:0]  amt;
      logic              dir;
   } shift_cmd_t;

endpackage

// File: rtl/barrel_shifter.sv
// 32-bit combinational logical barrel shifter, zero fill; dir 0 = left, 1 = right.
module barrel_shifter (
   input  logic [31:0] data_in,
   input  logic [4:0]  shift_amt,
   input  logic        dir,
   output logic [31:0] data_out
);

   assign data_out = dir ? (data_in >> shift_amt) : (data_in << shift_amt);

endmodule

// File: rtl/shift_cmd_fifo.sv
// Command FIFO: DEPTH-entry storage with wrapping pointers and a separate
// occupancy counter that drives the full/empty flags.
module shift_cmd_fifo
   import shift_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   push,
   input  shift_cmd_t             push_cmd,
   input  logic                   pop,
   output shift_cmd_t             head_cmd,
   output logic [$clog2(DEPTH):0] level,
   output logic                   full,
   output logic                   empty
);

   localparam int PTR_W = $clog2(DEPTH);

   shift_cmd_t       mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   level <= level + 1'b1;
            2'b01:   level <= level - 1'b1;
            default: level <= level;
         endcase
      end
   end

   // Storage carries no reset; only entries below level are ever read.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= push_cmd;
   end

   assign head_cmd = mem[rd_ptr];
   assign full     = (level == (PTR_W+1)'(DEPTH));
   assign empty    = (level == '0);

endmodule

// File: rtl/shift_cmd_queue.sv
// Shift command front end: buffers commands in a FIFO, shifts the head entry and
// registers the result behind an independent valid/ready output handshake.
module shift_cmd_queue
   import shift_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [31:0]            in_data,
   input  logic [4:0]             in_amt,
   input  logic                   in_dir,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [31:0]            out_data,
   output logic [$clog2(DEPTH):0] level
);

   shift_cmd_t         push_cmd;
   shift_cmd_t         head_cmd;
   logic               full;
   logic               empty;
   logic               push;
   logic               load;
   logic [DATA_W-1:0]  shift_res_p0;

   // No full-bypass: a pop in the same cycle does not open a slot for the push.
   assign in_ready = !full && !rst;
   assign push     = in_valid && in_ready;
   assign load     = !empty && (!out_valid || out_ready);
   assign push_cmd = '{data: in_data, amt: in_amt, dir: in_dir};

   shift_cmd_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk      (clk),
      .rst      (rst),
      .push     (push),
      .push_cmd (push_cmd),
      .pop      (load),
      .head_cmd (head_cmd),
      .level    (level),
      .full     (full),
      .empty    (empty)
   );

   barrel_shifter u_shifter (
      .data_in   (head_cmd.data),
      .shift_amt (head_cmd.amt),
      .dir       (head_cmd.dir),
      .data_out  (shift_res_p0)
   );

   // Stage p0 -> output register: head result captured as it is popped.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid <= 1'b0;
         out_data  <= '0;
      end else if (load) begin
         out_valid <= 1'b1;
         out_data  <= shift_res_p0;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_shift_cmd_queue.sv
// Scoreboard bench for shift_cmd_queue: directed commands with hand-computed
// results, queue-based ordering check, backpressure, full, wrap and reset cases.
module tb_shift_cmd_queue;

   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [31:0] in_data = '0;
   logic [4:0]  in_amt = '0;
   logic        in_dir = 1'b0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [31:0] out_data;
   logic [2:0]  level;

   always #5 clk = ~clk;

   shift_cmd_queue #(.DEPTH(DEPTH)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_amt    (in_amt),
      .in_dir    (in_dir),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .level     (level)
   );

   int errors = 0;
   int checks = 0;
   logic [31:0] sb [$];

   logic [31:0] t_data [8] = '{32'h12345678, 32'h12345678, 32'hFFFFFFFF, 32'hFFFFFFFF,
                               32'hA5A5A5A5, 32'hA5A5A5A5, 32'h00000001, 32'h80000000};
   logic [4:0]  t_amt  [8] = '{5'd4, 5'd4, 5'd31, 5'd31, 5'd8, 5'd8, 5'd16, 5'd1};
   logic        t_dir  [8] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
   logic [31:0] t_exp  [8] = '{32'h23456780, 32'h01234567, 32'h80000000, 32'h00000001,
                               32'hA5A5A500, 32'h00A5A5A5, 32'h00010000, 32'h40000000};

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] ref_shift(input logic [31:0] d, input logic [4:0] a,
                                             input logic dr);
      return dr ? (d >> a) : (d << a);
   endfunction

   // Monitor: pops and compares on every completed output handshake.
   bit tp_en = 0;
   int run = 0;
   int max_run = 0;
   int max_level = 0;

   always @(negedge clk) begin
      if (!rst && out_valid) run++;
      else run = 0;
      if (tp_en) begin
         if (run > max_run) max_run = run;
         if (int'(level) > max_level) max_level = int'(level);
      end
      if (!rst && out_valid && out_ready) begin
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL out_data: got %h expected none (scoreboard empty)", out_data);
         end else begin
            check("out_data", out_data, sb.pop_front());
         end
      end
   end

   // Holds the command until accepted; expected result queued on the accepting edge.
   task automatic push_cmd(input logic [31:0] d, input logic [4:0] a, input logic dr,
                           input logic [31:0] e, input bit rnd, output int tries);
      bit done = 0;
      tries = 0;
      in_valid = 1'b1;
      in_data  = d;
      in_amt   = a;
      in_dir   = dr;
      while (!done) begin
         if (rnd) out_ready = 1'($urandom_range(0, 1));
         @(negedge clk);
         if (in_ready) begin
            sb.push_back(e);
            done = 1;
         end
         @(posedge clk);
         #1;
         tries++;
         if (!done && tries > 60) begin
            checks++;
            errors++;
            $display("FAIL push_timeout: got no accept after %0d cycles expected accept", tries);
            done = 1;
         end
      end
   endtask

   task automatic drain(input string name);
      int n = 0;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      while ((sb.size() != 0 || out_valid) && n < 40) begin
         @(posedge clk);
         #1;
         n++;
      end
      check(name, 32'(sb.size()), 32'd0);
   endtask

   initial begin
      int tries;
      int total;
      int acc;
      logic [31:0] d;
      logic [4:0]  a;
      logic        dr;

      #1 rst = 1'b1;
      @(negedge clk);
      check("rst_in_ready", 32'(in_ready), 32'd0);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_out_data", out_data, 32'h0);
      check("rst_level", 32'(level), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      check("in_ready_after_rst", 32'(in_ready), 32'd1);

      // Basic directed commands with latency check
      out_ready = 1'b1;
      push_cmd(32'h0000000F, 5'd1, 1'b0, 32'h0000001E, 0, tries);
      check("latency_edge_n1", 32'(out_valid), 32'd0);
      push_cmd(32'h0000000F, 5'd3, 1'b1, 32'h00000001, 0, tries);
      check("latency_edge_n2", 32'(out_valid), 32'd1);
      push_cmd(32'h0000000F, 5'd0, 1'b0, 32'h0000000F, 0, tries);
      push_cmd(32'h0000000F, 5'd5, 1'b0, 32'h000001E0, 0, tries);
      drain("basic_drain");

      // Throughput: 8 back-to-back commands
      max_run = 0;
      max_level = 0;
      tp_en = 1;
      total = 0;
      out_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         push_cmd(t_data[i], t_amt[i], t_dir[i], t_exp[i], 0, tries);
         total += tries;
      end
      in_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      tp_en = 0;
      check("tp_accept_cycles", 32'(total), 32'd8);
      check("tp_valid_run", 32'(max_run), 32'd8);
      check("tp_level_le1", 32'(max_level <= 1), 32'd1);
      drain("tp_drain");

      // Backpressure until full
      out_ready = 1'b0;
      acc = 0;
      for (int c = 0; c < 8; c++) begin
         in_valid = 1'b1;
         in_data  = t_data[acc];
         in_amt   = t_amt[acc];
         in_dir   = t_dir[acc];
         @(negedge clk);
         if (in_ready) begin
            sb.push_back(t_exp[acc]);
            acc++;
         end
         @(posedge clk);
         #1;
      end
      check("bp_accepted", 32'(acc), 32'd5);
      check("bp_level", 32'(level), 32'd4);
      check("bp_in_ready", 32'(in_ready), 32'd0);
      check("bp_out_valid", 32'(out_valid), 32'd1);
      check("bp_out_stable", out_data, 32'h23456780);

      // Full with a one-cycle pop: push refused this cycle, accepted the next
      in_data = t_data[5];
      in_amt  = t_amt[5];
      in_dir  = t_dir[5];
      out_ready = 1'b1;
      @(negedge clk);
      check("full_pop_in_ready", 32'(in_ready), 32'd0);
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      check("full_pop_level", 32'(level), 32'd3);
      @(negedge clk);
      check("after_pop_in_ready", 32'(in_ready), 32'd1);
      if (in_ready) sb.push_back(t_exp[5]);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      check("refill_level", 32'(level), 32'd4);
      drain("bp_drain");

      // Wrap-around with random commands and random backpressure
      for (int i = 0; i < 3 * DEPTH; i++) begin
         d  = $urandom;
         a  = 5'($urandom_range(0, 31));
         dr = 1'($urandom_range(0, 1));
         push_cmd(d, a, dr, ref_shift(d, a, dr), 1, tries);
      end
      drain("wrap_drain");

      // Asynchronous reset with buffered commands
      out_ready = 1'b0;
      for (int i = 0; i < 4; i++) push_cmd(t_data[i], t_amt[i], t_dir[i], t_exp[i], 0, tries);
      in_valid = 1'b0;
      check("pre_rst_level", 32'(level), 32'd3);
      check("pre_rst_out_valid", 32'(out_valid), 32'd1);
      @(negedge clk);
      #2 rst = 1'b1;
      #1;
      check("async_rst_out_valid", 32'(out_valid), 32'd0);
      check("async_rst_out_data", out_data, 32'h0);
      check("async_rst_level", 32'(level), 32'd0);
      check("async_rst_in_ready", 32'(in_ready), 32'd0);
      sb.delete();
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      out_ready = 1'b1;
      push_cmd(32'h80000000, 5'd31, 1'b1, 32'h00000001, 0, tries);
      drain("post_rst_drain");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/shift_cmd_queue.md
# shift_cmd_queue

Command-buffering front end for the 32-bit combinational `barrel_shifter`. Accepts shift commands (operand, amount, direction) over a valid/ready handshake and holds them in a small FIFO. It presents the head command to the shifter and captures the shifted result in an output register with its own valid/ready handshake. This decouples upstream producers from downstream consumers while sustaining one shift per cycle.

## Interface
Parameters:
- `DEPTH`, 4: command FIFO entries; power of two, ≥2.

Ports:
- `clk`  in  1: single clock; all state on rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `in_valid`  in  1: command present on `in_data`/`in_amt`/`in_dir`.
- `in_ready`  out  1: FIFO can accept; equals `level != DEPTH`, forced 0 while `rst` high.
- `in_data`  in  32: operand.
- `in_amt`  in  5: shift amount, 0–31.
- `in_dir`  in  1: 0 = logical left, 1 = logical right.
- `out_valid`  out  1: `out_data` holds a result.
- `out_ready`  in  1: consumer takes result.
- `out_data`  out  32: registered shifter result.
- `level`  out  $clog2(DEPTH)+1: FIFO occupancy, 0..DEPTH; excludes the output register.

## Operation
- Push: `in_valid && in_ready` at an edge writes the command at the write pointer; write pointer +1 mod DEPTH.
- Head (read-pointer entry) drives `barrel_shifter` combinationally: `data_in`=operand, `shift_amt`=amount, `dir`=direction.
- Load: when `level != 0` and (`!out_valid || out_ready`), the shifter output is written to `out_data`, `out_valid` is set, and the read pointer advances (pop).
- Drain: when `out_valid && out_ready` and no load occurs, `out_valid` clears; `out_data` holds its last value.
- Simultaneous push and pop: `level` is unchanged. Both pointers move.
- Full (`level == DEPTH`): `in_ready` = 0 even if a pop occurs in the same cycle. There is no full-bypass.
- Empty: there is no input-to-output bypass. A command always passes through the FIFO.
- Pointers are `$clog2(DEPTH)` bits and wrap naturally. `level` is a separate counter.
- Shift semantics come from `barrel_shifter`: logical shift with zero fill, and amount 0 returns the operand unchanged.
- Commands leave in strict FIFO order. None is dropped or duplicated.

## Timing
- Reset values: `out_valid`=0, `out_data`=32'h0, `level`=0, pointers=0, `in_ready`=0 while reset is asserted and 1 from the first cycle after release.
- Latency: a command accepted at edge N is loaded at edge N+1. `out_valid` is high in the cycle after edge N+1, so the minimum latency is 2 cycles.
- Throughput: 1 command per cycle when `out_ready` is held high.
- Backpressure: with `out_ready`=0, the block holds DEPTH commands in the FIFO plus 1 in the output register. `out_data` is stable while `out_valid && !out_ready`.
- Reset mid-operation: asynchronous assertion immediately clears all state and discards buffered commands. Outputs take their reset values within the same cycle.
- `in_*` are sampled only on handshake edges. Their values are don't-care when `in_valid`=0.

## Structure
- Shared package `shift_pkg`:
  - `DATA_W`=32 and `AMT_W`=5.
  - `DIR_LEFT`=1'b0 and `DIR_RIGHT`=1'b1.
  - `shift_cmd_t` struct: data, amt, dir.
- Sub-module `shift_cmd_fifo`: storage, pointers, `level`, full/empty flags. This is a natural split.
- Top `shift_cmd_queue` instantiates `shift_cmd_fifo`, the existing `barrel_shifter` unchanged, and the output register/handshake logic.

## Test plan
- Basic: push 0x0000000F with amt 1/dir 0, amt 3/dir 1, amt 0/dir 0, and amt 5/dir 0, with `out_ready`=1. Required outputs, in order: 0x0000001E, 0x00000001, 0x0000000F, 0x000001E0. The first `out_valid` appears 2 cycles after the first accept.
- Throughput: push 8 back-to-back commands with `out_ready`=1 throughout. Expect 8 consecutive `out_valid` cycles with results in order. `in_ready` stays 1 and `level` never exceeds 1.
- Backpressure/full (DEPTH=4): hold `out_ready`=0 and push continuously. Exactly 5 commands are accepted. `level`=4, `in_ready`=0, and `out_data` stays stable. Releasing `out_ready` drains all 5 in order.
- Full with simultaneous pop: at `level`=4 with `in_valid`=1, pulse `out_ready` for 1 cycle. The push is not accepted that cycle and `level`=3 afterwards. The push is accepted next cycle and `level` returns to 4.
- Wrap-around: push and pop 3×DEPTH commands with random amounts and directions under random `out_ready`. Compare every result against a shift reference model. No loss or reordering is allowed.
- Reset mid-operation: with 3 commands buffered and `out_valid`=1, assert `rst` asynchronously between edges. Immediately: `out_valid`=0, `out_data`=0, `level`=0. After release, the first new command 0x80000000 with amt 31/dir 1 yields 0x00000001.
